// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream/decrypt core.
package rc4_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StRdSi,
    StWaitSi,
    StCalcJ,
    StRdSj,
    StWaitSj,
    StWrSi,
    StWrSj,
    StRdF,
    StWaitF,
    StWrOut,
    StDone
  } rc4_state_e;

  localparam logic [7:0] SPACE_CHAR  = 8'h20;
  localparam logic [7:0] DEF_CHAR_LO = 8'h61;
  localparam logic [7:0] DEF_CHAR_HI = 8'h7A;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext validity test: inclusive range plus optional space.
module rc4_char_check
  import rc4_pkg::*;
#(
  parameter logic [7:0] CHAR_LO     = DEF_CHAR_LO,
  parameter logic [7:0] CHAR_HI     = DEF_CHAR_HI,
  parameter bit         ALLOW_SPACE = 1'b1
) (
  input  logic [7:0] ch,
  output logic       valid
);

  always_comb begin
    valid = ((ch >= CHAR_LO) && (ch <= CHAR_HI)) || (ALLOW_SPACE && (ch == SPACE_CHAR));
  end

endmodule

// File: rtl/rc4_prga_core.sv
// RC4 PRGA sequencer: walks a preloaded S RAM, XORs the keystream with a
// ciphertext ROM and writes plaintext, optionally aborting on an invalid byte.
module rc4_prga_core
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN     = 32,
  parameter int unsigned K_W         = 5,
  parameter int unsigned RD_LAT      = 1,
  parameter bit          CHECK_EN    = 1'b1,
  parameter logic [7:0]  CHAR_LO     = DEF_CHAR_LO,
  parameter logic [7:0]  CHAR_HI     = DEF_CHAR_HI,
  parameter bit          ALLOW_SPACE = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  output logic [7:0]     s_addr,
  output logic [7:0]     s_wdata,
  input  logic [7:0]     s_rdata,
  output logic           s_wren,
  output logic [K_W-1:0] msg_addr,
  input  logic [7:0]     msg_rdata,
  output logic [K_W-1:0] out_addr,
  output logic [7:0]     out_wdata,
  output logic           out_wren,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [7:0]     last_byte
);

  localparam logic [1:0]     WaitInit = 2'(RD_LAT - 1);
  localparam logic [K_W-1:0] KLast    = K_W'(MSG_LEN - 1);

  rc4_state_e     state_q, state_d;
  logic [7:0]     i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, last_q, last_d;
  logic [K_W-1:0] k_q, k_d;
  logic [1:0]     wait_q, wait_d;
  logic           pass_q, pass_d;
  logic [7:0]     pt;
  logic           pt_ok;

  assign pt = s_rdata ^ msg_rdata;

  rc4_char_check #(
    .CHAR_LO    (CHAR_LO),
    .CHAR_HI    (CHAR_HI),
    .ALLOW_SPACE(ALLOW_SPACE)
  ) u_char_check (
    .ch   (pt),
    .valid(pt_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      wait_q  <= '0;
      pass_q  <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      wait_q  <= wait_d;
      pass_q  <= pass_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    si_d      = si_q;
    sj_d      = sj_q;
    wait_d    = wait_q;
    pass_d    = pass_q;
    last_d    = last_q;
    s_addr    = '0;
    s_wdata   = '0;
    s_wren    = 1'b0;
    msg_addr  = '0;
    out_addr  = '0;
    out_wdata = '0;
    out_wren  = 1'b0;

    // Read addresses stay stable through each wait state so any RAM latency works.
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          pass_d  = 1'b0;
          state_d = StRdSi;
        end
      end
      StRdSi: begin
        s_addr  = i_q + 8'd1;
        i_d     = i_q + 8'd1;
        wait_d  = WaitInit;
        state_d = StWaitSi;
      end
      StWaitSi: begin
        s_addr = i_q;
        if (wait_q == 2'd0) state_d = StCalcJ;
        else                wait_d  = wait_q - 2'd1;
      end
      StCalcJ: begin
        si_d    = s_rdata;
        j_d     = j_q + s_rdata;
        state_d = StRdSj;
      end
      StRdSj: begin
        s_addr  = j_q;
        wait_d  = WaitInit;
        state_d = StWaitSj;
      end
      StWaitSj: begin
        s_addr = j_q;
        if (wait_q == 2'd0) state_d = StWrSi;
        else                wait_d  = wait_q - 2'd1;
      end
      StWrSi: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_wren  = 1'b1;
        sj_d    = s_rdata;
        state_d = StWrSj;
      end
      StWrSj: begin
        s_addr  = i_q;
        s_wdata = sj_q;
        s_wren  = 1'b1;
        state_d = StRdF;
      end
      StRdF: begin
        s_addr   = si_q + sj_q;
        msg_addr = k_q;
        wait_d   = WaitInit;
        state_d  = StWaitF;
      end
      StWaitF: begin
        s_addr   = si_q + sj_q;
        msg_addr = k_q;
        if (wait_q == 2'd0) state_d = StWrOut;
        else                wait_d  = wait_q - 2'd1;
      end
      StWrOut: begin
        s_addr    = si_q + sj_q;
        msg_addr  = k_q;
        out_addr  = k_q;
        out_wdata = pt;
        out_wren  = 1'b1;
        last_d    = pt;
        if (CHECK_EN && !pt_ok) begin
          pass_d  = 1'b0;
          state_d = StDone;
        end else if (k_q == KLast) begin
          pass_d  = 1'b1;
          state_d = StDone;
        end else begin
          k_d     = k_q + K_W'(1);
          state_d = StRdSi;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      pass_d  = 1'b0;
    end
  end

  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign last_byte = last_q;

endmodule

// File: tb/tb_rc4_prga_core.sv
// Directed bench: four core configurations sharing clock and reset, each with
// its own S RAM / ROM / output RAM models.
module tb_rc4_prga_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] start_v, abort_v, load_v;
  logic [3:0] busy_v, done_v, pass_v, en_v, any_v;

  logic [7:0] s_init [256];
  logic [7:0] ref_s  [256];
  logic [7:0] plain3 [256];
  logic [7:0] rom    [4][256];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned ML = (g == 3) ? 256 : 9;
    localparam int unsigned KW = (g == 3) ? 8 : 4;
    localparam int unsigned RL = (g == 2) ? 3 : ((g == 3) ? 2 : 1);
    localparam bit          CE = (g == 1) || (g == 3);

    logic [7:0]    s_addr, s_wdata, s_rdata, msg_rdata, out_wdata, last_byte;
    logic [KW-1:0] msg_addr, out_addr;
    logic          s_wren, out_wren, busy, done, pass;
    logic [7:0]    s_mem   [256];
    logic [7:0]    out_mem [256];
    logic [7:0]    s_pipe  [3];
    logic [7:0]    m_pipe  [3];
    logic [7:0]    m_idx, o_idx;
    int            wr_cnt;

    assign m_idx = 8'(msg_addr);
    assign o_idx = 8'(out_addr);

    rc4_prga_core #(
      .MSG_LEN (ML),
      .K_W     (KW),
      .RD_LAT  (RL),
      .CHECK_EN(CE)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start_v[g]),
      .abort    (abort_v[g]),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_rdata  (s_rdata),
      .s_wren   (s_wren),
      .msg_addr (msg_addr),
      .msg_rdata(msg_rdata),
      .out_addr (out_addr),
      .out_wdata(out_wdata),
      .out_wren (out_wren),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .last_byte(last_byte)
    );

    always @(posedge clk) begin
      if (load_v[g]) begin
        for (int a = 0; a < 256; a++) begin
          s_mem[a]   <= s_init[a];
          out_mem[a] <= 8'h00;
        end
        wr_cnt <= 0;
      end else begin
        if (s_wren) s_mem[s_addr] <= s_wdata;
        if (out_wren) begin
          out_mem[o_idx] <= out_wdata;
          wr_cnt         <= wr_cnt + 1;
        end
      end
      s_pipe[0] <= s_mem[s_addr];
      s_pipe[1] <= s_pipe[0];
      s_pipe[2] <= s_pipe[1];
      m_pipe[0] <= rom[g][m_idx];
      m_pipe[1] <= m_pipe[0];
      m_pipe[2] <= m_pipe[1];
    end

    assign s_rdata   = s_pipe[RL-1];
    assign msg_rdata = m_pipe[RL-1];
    assign busy_v[g] = busy;
    assign done_v[g] = done;
    assign pass_v[g] = pass;
    assign en_v[g]   = s_wren | out_wren;
    assign any_v[g]  = |{s_addr, s_wdata, s_wren, msg_addr, out_addr, out_wdata, out_wren,
                         busy, done, pass, last_byte};
  end

  task automatic load(input int g);
    @(negedge clk);
    load_v[g] = 1'b1;
    @(negedge clk);
    load_v[g] = 1'b0;
  endtask

  // cycles = clock edges from the edge that accepted start to done (or to the
  // edge after abort).
  task automatic run_inst(input int g, input int poke_at, input int abort_at, output int cycles);
    cycles = 0;
    @(negedge clk);
    start_v[g] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[g] = 1'b0;
    check_eq("busy_after_start", 32'(busy_v[g]), 1);
    while (cycles < 5000) begin
      start_v[g] = (cycles == poke_at);
      abort_v[g] = (cycles == abort_at);
      @(posedge clk);
      @(negedge clk);
      cycles++;
      start_v[g] = 1'b0;
      abort_v[g] = 1'b0;
      if (done_v[g] || (abort_at >= 0 && cycles == abort_at + 1)) break;
    end
  endtask

  initial begin
    string      key_str   = "Key";
    string      plain_str = "Plaintext";
    logic [7:0] ct [9]    = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] jj, ii, tmp, ks;
    int         cyc, bad;

    reset   = 1'b1;
    start_v = '0;
    abort_v = '0;
    load_v  = '0;

    // KSA("Key") reference table
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    jj = 8'h00;
    for (int a = 0; a < 256; a++) begin
      jj        = jj + s_init[a] + key_str[a % 3];
      tmp       = s_init[a];
      s_init[a] = s_init[jj];
      s_init[jj] = tmp;
    end
    for (int g = 0; g < 3; g++)
      for (int a = 0; a < 256; a++) rom[g][a] = (a < 9) ? ct[a] : 8'h00;

    // PRGA reference for the 256-byte run: lowercase text with spaces mixed in
    for (int a = 0; a < 256; a++) ref_s[a] = s_init[a];
    ii = 8'h00;
    jj = 8'h00;
    for (int k = 0; k < 256; k++) begin
      ii        = ii + 8'd1;
      jj        = jj + ref_s[ii];
      tmp       = ref_s[ii];
      ref_s[ii] = ref_s[jj];
      ref_s[jj] = tmp;
      ks        = ref_s[8'(ref_s[ii] + ref_s[jj])];
      plain3[k] = (k % 7 == 3) ? 8'h20 : 8'(8'h61 + k % 26);
      rom[3][k] = plain3[k] ^ ks;
    end

    repeat (2) @(negedge clk);
    check_eq("reset_outputs", 32'(any_v), 0);
    check_eq("reset_busy", 32'(busy_v), 0);
    check_eq("reset_done", 32'(done_v), 0);
    reset = 1'b0;

    // Base run, with a start pulse while busy that must be ignored
    load(0);
    run_inst(0, 40, -1, cyc);
    check_eq("g0_cycles", cyc, 90);
    check_eq("g0_pass", 32'(pass_v[0]), 1);
    check_eq("g0_busy_in_done", 32'(busy_v[0]), 0);
    check_eq("g0_wr_cnt", g_dut[0].wr_cnt, 9);
    check_eq("g0_last_byte", 32'(g_dut[0].last_byte), 32'h74);
    for (int k = 0; k < 9; k++) check_eq("g0_out", 32'(g_dut[0].out_mem[k]), 32'(plain_str[k]));
    repeat (3) @(negedge clk);
    check_eq("g0_done_level", 32'(done_v[0]), 1);

    // Validity check aborts on 'P'
    load(1);
    run_inst(1, -1, -1, cyc);
    check_eq("g1_cycles", cyc, 10);
    check_eq("g1_pass", 32'(pass_v[1]), 0);
    check_eq("g1_done", 32'(done_v[1]), 1);
    check_eq("g1_wr_cnt", g_dut[1].wr_cnt, 1);
    check_eq("g1_out0", 32'(g_dut[1].out_mem[0]), 32'h50);
    check_eq("g1_out1_unwritten", 32'(g_dut[1].out_mem[1]), 0);

    // Three-cycle read latency
    load(2);
    run_inst(2, -1, -1, cyc);
    check_eq("g2_cycles", cyc, 144);
    check_eq("g2_pass", 32'(pass_v[2]), 1);
    bad = 0;
    for (int k = 0; k < 9; k++) if (g_dut[2].out_mem[k] !== 8'(plain_str[k])) bad++;
    check_eq("g2_out_bad", bad, 0);

    // Full 256-byte run: i wraps, final S compared to the model
    load(3);
    run_inst(3, -1, -1, cyc);
    check_eq("g3_cycles", cyc, 3328);
    check_eq("g3_pass", 32'(pass_v[3]), 1);
    check_eq("g3_wr_cnt", g_dut[3].wr_cnt, 256);
    bad = 0;
    for (int k = 0; k < 256; k++) if (g_dut[3].out_mem[k] !== plain3[k]) bad++;
    check_eq("g3_out_bad", bad, 0);
    bad = 0;
    for (int a = 0; a < 256; a++) if (g_dut[3].s_mem[a] !== ref_s[a]) bad++;
    check_eq("g3_final_s_bad", bad, 0);

    // Abort during byte 2, then a clean rerun
    load(0);
    run_inst(0, -1, 25, cyc);
    check_eq("abort_cycles", cyc, 26);
    check_eq("abort_busy", 32'(busy_v[0]), 0);
    check_eq("abort_done", 32'(done_v[0]), 0);
    check_eq("abort_pass", 32'(pass_v[0]), 0);
    check_eq("abort_enables", 32'(en_v[0]), 0);
    repeat (30) @(negedge clk);
    check_eq("abort_no_more_writes", g_dut[0].wr_cnt, 2);
    load(0);
    run_inst(0, -1, -1, cyc);
    check_eq("rerun_cycles", cyc, 90);
    check_eq("rerun_pass", 32'(pass_v[0]), 1);
    bad = 0;
    for (int k = 0; k < 9; k++) if (g_dut[0].out_mem[k] !== 8'(plain_str[k])) bad++;
    check_eq("rerun_out_bad", bad, 0);

    // Reset mid-run clears outputs immediately
    load(0);
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (33) @(negedge clk);
    check_eq("pre_reset_busy", 32'(busy_v[0]), 1);
    #1 reset = 1'b1;
    #1;
    check_eq("midrun_reset_outputs", 32'(any_v[0]), 0);
    check_eq("midrun_reset_busy", 32'(busy_v[0]), 0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rc4_prga_core.md
RC4_PRGA_CORE -- requirements
Module: rc4_prga_core

Interface
REQ-001 Parameter MSG_LEN, default 32: number of ciphertext bytes processed per run (1..256).
REQ-002 Parameter K_W, default 5: width of message/output address, ceil(log2(MSG_LEN)), minimum 1.
REQ-003 Parameter RD_LAT, default 1: read latency in cycles of the S RAM and message ROM (1..3).
REQ-004 Parameter CHECK_EN, default 1: 1 enables the plaintext validity check and early abort.
REQ-005 Parameters CHAR_LO, default 8'h61, and CHAR_HI, default 8'h7A: inclusive valid plaintext range.
REQ-006 Parameter ALLOW_SPACE, default 1: 8'h20 is also valid when set.
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  one-cycle request; sampled only in IDLE or DONE.
REQ-010 abort  in  1  synchronous cancel; returns the FSM to IDLE next cycle.
REQ-011 s_addr, s_wdata  out  8  S RAM address and write data.
REQ-012 s_rdata  in  8  S RAM read data.
REQ-013 s_wren  out  1  S RAM write enable.
REQ-014 msg_addr  out  K_W  ciphertext ROM address; msg_rdata  in  8  ciphertext byte.
REQ-015 out_addr  out  K_W, out_wdata  out  8, out_wren  out  1: plaintext RAM write port.
REQ-016 busy  out  1  high from the cycle after accepted start until DONE.
REQ-017 done  out  1  level, high in DONE until next accepted start, abort or reset.
REQ-018 pass  out  1  valid with done; 1 = all MSG_LEN bytes passed the check (always 1 if CHECK_EN=0).
REQ-019 last_byte  out  8  most recent plaintext byte written, for board display.

Function
REQ-020 States: IDLE, RD_SI, WAIT_SI, CALC_J, RD_SJ, WAIT_SJ, WR_SI, WR_SJ, RD_F, WAIT_F, WR_OUT, DONE.
REQ-021 Accepted start clears i, j and k to 0 and enters RD_SI; start in any other state is ignored.
REQ-022 RD_SI: i <= i+1 (mod 256), s_addr = i+1; WAIT_SI holds RD_LAT cycles.
REQ-023 CALC_J: si <= s_rdata; j <= j + s_rdata (mod 256).
REQ-024 RD_SJ: s_addr = j; WAIT_SJ holds RD_LAT cycles.
REQ-025 WR_SI: sj <= s_rdata; write s[j] = si, s_wren high for exactly 1 cycle.
REQ-026 WR_SJ: write s[i] = sj, s_wren high for exactly 1 cycle; when i==j both writes target the same address, and s[i] ends holding sj.
REQ-027 RD_F: s_addr = si+sj (mod 256), msg_addr = k, both presented together; WAIT_F holds RD_LAT cycles.
REQ-028 WR_OUT: out_addr = k, out_wdata = s_rdata ^ msg_rdata, out_wren high for 1 cycle, last_byte updated.
REQ-029 Byte period is fixed at 7 + 3*RD_LAT cycles: 10 at RD_LAT=1.
REQ-030 Each write enable is high only in its own state; no two enables overlap.
REQ-031 With CHECK_EN=1, an out-of-range byte is still written, then the FSM goes to DONE with pass=0.
REQ-032 When k==MSG_LEN-1 and the byte is valid, WR_OUT goes to DONE with pass=1; otherwise k <= k+1 and the FSM returns to RD_SI.
REQ-033 i and j wrap modulo 256; k never exceeds MSG_LEN-1.
REQ-034 abort in any state: IDLE next cycle, all enables low, done=0, pass=0; abort overrides a simultaneous start.

Reset
REQ-035 reset forces IDLE; i, j, k, si and sj go to 0; all outputs go to 0, including every enable, busy, done, pass and last_byte.
REQ-036 reset mid-run leaves S and output RAM contents undefined; a new start is required.

Structure
REQ-037 Package rc4_pkg holds the state enum type and the constants SPACE_CHAR, DEF_CHAR_LO and DEF_CHAR_HI.
REQ-038 One sub-module, rc4_char_check (combinational range/space test), is instantiated once.
REQ-039 The RD_LAT wait states share one 2-bit down-counter.

Verification
REQ-040 Preload S = KSA("Key"), MSG_LEN=9, CHECK_EN=0, ROM = BB F3 16 E8 D9 40 AF 0A D3 -> out RAM = "Plaintext", pass=1, done 90 cycles after start.
REQ-041 Same S, CHECK_EN=1 with default range -> byte 0 ('P') written, done after 10 cycles, pass=0, exactly one out_wren pulse.
REQ-042 RD_LAT=3, same vector as REQ-040 -> identical output, byte period 16 cycles.
REQ-043 Assert abort at cycle 25 of a run -> IDLE next cycle, no further writes; a new start gives a correct full result.
REQ-044 MSG_LEN=256, lowercase plaintext -> k wraps nowhere, i wraps 255->0, pass=1, and the final S matches the reference model.
REQ-045 Pulse start while busy, and assert reset mid-run -> start ignored; on reset, all outputs are 0 within the same cycle.
